// File: rtl/weight_bank.sv
// weight_bank
// Holds one signed weight per gesture class for every (bin, cy, cx) cell.
// After reset the contents are regenerated by an INIT sweep (one cell per
// cycle), then lookups are served through a two-stage pipeline
// (storage read, output register) with valid/ready handshakes.
//
// Optional feature macro: WEIGHT_BANK_WR_EN
//   defined   -> wr_en/wr_class/wr_addr/wr_data ports exist; RUN-state writes
//                overwrite single class weights (read-first on collisions)
//   undefined -> no write ports; contents are read-only after INIT
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   init_busy    high while default contents are generated
//   req_valid    lookup request valid          req_ready  request accepted
//   req_addr     cell address (bin*G*G + cy*G + cx)
//   rsp_valid    response valid                rsp_ready  response taken
//   rsp_addr     echoed request address
//   rsp_weights  class k weight at [k*WEIGHT_BITS +: WEIGHT_BITS]
//   wr_*         weight overwrite port (WEIGHT_BANK_WR_EN only)
module weight_bank #(
    parameter int NUM_CLASSES = 4,
    parameter int NUM_BINS    = 4,
    parameter int GRID_SIZE   = 16,
    parameter int WEIGHT_BITS = 8,
    parameter int WDIST_SHIFT = 0,
    localparam int NUM_CELLS  = NUM_BINS * GRID_SIZE * GRID_SIZE,
    localparam int AW         = $clog2(NUM_CELLS),
    localparam int CW         = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic                               init_busy,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [AW-1:0]                      req_addr,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [AW-1:0]                      rsp_addr,
    output logic [NUM_CLASSES*WEIGHT_BITS-1:0] rsp_weights
`ifdef WEIGHT_BANK_WR_EN
    ,
    input  logic                               wr_en,
    input  logic [CW-1:0]                      wr_class,
    input  logic [AW-1:0]                      wr_addr,
    input  logic [WEIGHT_BITS-1:0]             wr_data
`endif
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_CELLS - 1);

    state_t                               state;
    logic [AW-1:0]                        cnt;
    logic                                 advance;
    logic                                 s1_valid;
    logic [AW-1:0]                        s1_addr;
    logic [NUM_CLASSES*WEIGHT_BITS-1:0]   s1_data;

    logic                                 wr_en_i;
    logic [CW-1:0]                        wr_class_i;
    logic [AW-1:0]                        wr_addr_i;
    logic [WEIGHT_BITS-1:0]               wr_data_i;

`ifdef WEIGHT_BANK_WR_EN
    assign wr_en_i    = wr_en;
    assign wr_class_i = wr_class;
    assign wr_addr_i  = wr_addr;
    assign wr_data_i  = wr_data;
`else
    assign wr_en_i    = 1'b0;
    assign wr_class_i = '0;
    assign wr_addr_i  = '0;
    assign wr_data_i  = '0;
`endif

    // Default weight: signed distance from the grid centre, sign chosen by
    // whether the cell lies on the gesture's destination side and by the
    // temporal half of the bin. Classes beyond RIGHT hold zero.
    function automatic logic [WEIGHT_BITS-1:0] default_weight(input int cls, input int addr);
        int   half, bin, cy, cx, c, tphase, d, raw, wmax, wmin;
        logic dest;
        half   = GRID_SIZE / 2;
        bin    = addr / (GRID_SIZE * GRID_SIZE);
        cy     = (addr / GRID_SIZE) % GRID_SIZE;
        cx     = addr % GRID_SIZE;
        tphase = (bin >= NUM_BINS / 2) ? 1 : -1;
        c      = cy;
        dest   = 1'b0;
        case (cls)
            0:       begin c = cy; dest = (cy < half);  end
            1:       begin c = cy; dest = (cy >= half); end
            2:       begin c = cx; dest = (cx < half);  end
            3:       begin c = cx; dest = (cx >= half); end
            default: return '0;
        endcase
        d    = ((c < half) ? (half - c) : (c - half + 1)) <<< WDIST_SHIFT;
        raw  = dest ? (tphase * d) : (-tphase * d);
        wmax = (1 <<< (WEIGHT_BITS - 1)) - 1;
        wmin = -(1 <<< (WEIGHT_BITS - 1));
        if (raw > wmax) raw = wmax;
        if (raw < wmin) raw = wmin;
        return raw[WEIGHT_BITS-1:0];
    endfunction

    // Both pipeline stages move together whenever the output slot is free
    // or being consumed this cycle.
    assign advance   = !rsp_valid || rsp_ready;
    assign req_ready = (state == RUN) && advance;

    // One storage array per class so an overwrite touches a single class
    // while INIT can fill every class of a cell in the same cycle. The read
    // register samples the old contents on a same-cycle write (read-first).
    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_class
        logic [WEIGHT_BITS-1:0] mem [NUM_CELLS];
        logic [WEIGHT_BITS-1:0] rd;
        logic                   we;
        logic [AW-1:0]          waddr;
        logic [WEIGHT_BITS-1:0] wdata;

        always_comb begin
            we    = 1'b0;
            waddr = cnt;
            wdata = default_weight(k, int'(cnt));
            if (rst_n && state == INIT) begin
                we = 1'b1;
            end else if (rst_n && wr_en_i && int'(wr_class_i) == k) begin
                we    = 1'b1;
                waddr = wr_addr_i;
                wdata = wr_data_i;
            end
        end

        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
            if (advance) rd <= mem[req_addr];
        end

        assign s1_data[k*WEIGHT_BITS +: WEIGHT_BITS] = rd;
    end

    // INIT/RUN control plus pipeline valid/address/output registers. The
    // output register only reloads when stage 1 carries a real request, so
    // rsp_weights stays zero after reset until the first response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= INIT;
            cnt         <= '0;
            init_busy   <= 1'b1;
            s1_valid    <= 1'b0;
            s1_addr     <= '0;
            rsp_valid   <= 1'b0;
            rsp_addr    <= '0;
            rsp_weights <= '0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == LAST_ADDR) begin
                        state     <= RUN;
                        init_busy <= 1'b0;
                    end
                end
                RUN: begin
                    init_busy <= 1'b0;
                end
                default: begin
                    state <= INIT;
                end
            endcase
            if (advance) begin
                s1_valid  <= req_valid && req_ready;
                s1_addr   <= req_addr;
                rsp_valid <= s1_valid;
                if (s1_valid) begin
                    rsp_addr    <= s1_addr;
                    rsp_weights <= s1_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_bank.sv
// tb_weight_bank
// Directed bench for weight_bank: reset state, INIT length, default weights,
// saturation (second instance with WEIGHT_BITS=4, WDIST_SHIFT=1),
// back-to-back streaming with back-pressure, reset mid-run / mid-INIT and,
// with WEIGHT_BANK_WR_EN, the overwrite port.
module tb_weight_bank;

    logic        clk;
    logic        rst_n;
    logic        init_busy;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [9:0]  rsp_addr;
    logic [31:0] rsp_weights;

    logic        s_init_busy;
    logic        s_req_valid;
    logic        s_req_ready;
    logic [9:0]  s_req_addr;
    logic        s_rsp_valid;
    logic        s_rsp_ready;
    logic [9:0]  s_rsp_addr;
    logic [15:0] s_rsp_weights;

`ifdef WEIGHT_BANK_WR_EN
    logic        wr_en;
    logic [1:0]  wr_class;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        s_wr_en;
    logic [1:0]  s_wr_class;
    logic [9:0]  s_wr_addr;
    logic [3:0]  s_wr_data;
`endif

    int checks;
    int failures;

    weight_bank dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_busy   (init_busy),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_addr    (rsp_addr),
        .rsp_weights (rsp_weights)
`ifdef WEIGHT_BANK_WR_EN
        ,
        .wr_en       (wr_en),
        .wr_class    (wr_class),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
`endif
    );

    weight_bank #(.WEIGHT_BITS(4), .WDIST_SHIFT(1)) sat_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_busy   (s_init_busy),
        .req_valid   (s_req_valid),
        .req_ready   (s_req_ready),
        .req_addr    (s_req_addr),
        .rsp_valid   (s_rsp_valid),
        .rsp_ready   (s_rsp_ready),
        .rsp_addr    (s_rsp_addr),
        .rsp_weights (s_rsp_weights)
`ifdef WEIGHT_BANK_WR_EN
        ,
        .wr_en       (s_wr_en),
        .wr_class    (s_wr_class),
        .wr_addr     (s_wr_addr),
        .wr_data     (s_wr_data)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack4(input int w0, input int w1, input int w2, input int w3);
        logic [31:0] r;
        r = {w3[7:0], w2[7:0], w1[7:0], w0[7:0]};
        return r;
    endfunction

    // Counts INIT cycles from the negedge where rst_n was released.
    task automatic wait_init(output int cycles, output int ready_bad, output int rsp_seen);
        cycles = 0;
        ready_bad = 0;
        rsp_seen = 0;
        while (init_busy === 1'b1 && cycles < 2000) begin
            cycles++;
            if (req_ready !== 1'b0) ready_bad++;
            if (rsp_valid !== 1'b0) rsp_seen++;
            @(negedge clk);
        end
    endtask

    // Single lookup with rsp_ready high, starting from an idle pipeline.
    task automatic read_once(input logic [9:0] addr, output logic ready_seen,
                             output logic early_valid, output logic late_valid,
                             output logic [9:0] got_addr, output logic [31:0] got_w);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        ready_seen = req_ready;
        @(negedge clk);
        req_valid   = 1'b0;
        early_valid = rsp_valid;
        @(negedge clk);
        late_valid = rsp_valid;
        got_addr   = rsp_addr;
        got_w      = rsp_weights;
    endtask

    task automatic test_reset;
        checks++;
        if (init_busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl busy/rsp_valid/req_ready got=%b%b%b exp=100",
                     init_busy, rsp_valid, req_ready);
        end
        checks++;
        if (rsp_addr !== 10'd0 || rsp_weights !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_data addr=%h weights=%h exp=0/0", rsp_addr, rsp_weights);
        end
    endtask

    task automatic test_init_timing;
        int cyc, rbad, rseen;
        rst_n = 1'b1;
        wait_init(cyc, rbad, rseen);
        checks++;
        if (cyc != 1024) begin
            failures++;
            $display("[TB] FAIL init_length got=%0d exp=1024", cyc);
        end
        checks++;
        if (rbad != 0) begin
            failures++;
            $display("[TB] FAIL init_req_ready high_cycles=%0d exp=0", rbad);
        end
        #1;
        checks++;
        if (req_ready !== 1'b1 || s_init_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL run_entry req_ready=%b sat_busy=%b exp=1/0", req_ready, s_init_busy);
        end
    endtask

    task automatic test_defaults;
        logic [9:0]  addrs [6];
        logic [31:0] exp   [6];
        logic rdy, ev, lv;
        logic [9:0]  ga;
        logic [31:0] gw;
        addrs[0] = 10'd0;    exp[0] = pack4(-8,  8, -8,  8);
        addrs[1] = 10'd768;  exp[1] = pack4( 8, -8,  8, -8);
        addrs[2] = 10'd1023; exp[2] = pack4(-8,  8, -8,  8);
        addrs[3] = 10'd5;    exp[3] = pack4(-8,  8, -3,  3);
        addrs[4] = 10'd529;  exp[4] = pack4( 7, -7,  7, -7);
        addrs[5] = 10'd392;  exp[5] = pack4( 1, -1,  1, -1);
        for (int i = 0; i < 6; i++) begin
            read_once(addrs[i], rdy, ev, lv, ga, gw);
            checks++;
            if (rdy !== 1'b1 || ev !== 1'b0 || lv !== 1'b1) begin
                failures++;
                $display("[TB] FAIL latency addr=%0d ready/v1/v2 got=%b%b%b exp=101", addrs[i], rdy, ev, lv);
            end
            checks++;
            if (ga !== addrs[i] || gw !== exp[i]) begin
                failures++;
                $display("[TB] FAIL defaults addr got=%0d exp=%0d weights got=%h exp=%h",
                         ga, addrs[i], gw, exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_saturation;
        logic [9:0]  addrs [2];
        logic [15:0] exp   [2];
        addrs[0] = 10'd0;   exp[0] = 16'h7878;
        addrs[1] = 10'd392; exp[1] = 16'hE2E2;
        for (int i = 0; i < 2; i++) begin
            s_req_valid = 1'b1;
            s_req_addr  = addrs[i];
            @(negedge clk);
            s_req_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (s_rsp_valid !== 1'b1 || s_rsp_weights !== exp[i] || s_rsp_addr !== addrs[i]) begin
                failures++;
                $display("[TB] FAIL saturation addr=%0d valid=%b weights got=%h exp=%h",
                         addrs[i], s_rsp_valid, s_rsp_weights, exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp [4];
        int   req_idx, rsp_idx, stall, cyc, first_cyc, last_cyc;
        int   stable_bad, order_bad, stall_seen;
        logic seen, held_v;
        logic [9:0]  held_a;
        logic [31:0] held_w;
        exp[0] = pack4(-8, 8, -8, 8);
        exp[1] = pack4(-8, 8, -7, 7);
        exp[2] = pack4(-8, 8, -6, 6);
        exp[3] = pack4(-8, 8, -5, 5);
        for (int pass = 0; pass < 2; pass++) begin
            req_idx = 0; rsp_idx = 0; stall = 0; cyc = 0;
            first_cyc = -1; last_cyc = -1;
            stable_bad = 0; order_bad = 0; stall_seen = 0;
            seen = 1'b0; held_v = 1'b0; held_a = '0; held_w = '0;
            while (rsp_idx < 4 && cyc < 40) begin
                if (rsp_valid === 1'b1 && !seen) begin
                    seen  = 1'b1;
                    stall = (pass == 1) ? 3 : 0;
                end
                rsp_ready = (stall == 0);
                if (stall > 0) stall--;
                req_valid = (req_idx < 4);
                req_addr  = (req_idx < 4) ? 10'(req_idx) : 10'd0;
                #1;
                if (rsp_valid && !rsp_ready) begin
                    stall_seen++;
                    if (held_v && (rsp_addr !== held_a || rsp_weights !== held_w)) stable_bad++;
                    held_v = 1'b1;
                    held_a = rsp_addr;
                    held_w = rsp_weights;
                end
                if (rsp_valid && rsp_ready) begin
                    if (rsp_addr !== 10'(rsp_idx) || rsp_weights !== exp[rsp_idx]) begin
                        order_bad++;
                        $display("[TB] FAIL stream_data idx=%0d addr=%0d weights got=%h exp=%h",
                                 rsp_idx, rsp_addr, rsp_weights, exp[rsp_idx]);
                    end
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    rsp_idx++;
                    held_v = 1'b0;
                end
                if (req_valid && req_ready) req_idx++;
                cyc++;
                @(negedge clk);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            checks++;
            if (rsp_idx != 4 || order_bad != 0) begin
                failures++;
                $display("[TB] FAIL stream_count pass=%0d responses got=%0d exp=4 bad=%0d", pass, rsp_idx, order_bad);
            end
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stream_dup pass=%0d rsp_valid got=%b exp=0", pass, rsp_valid);
            end
            if (pass == 0) begin
                checks++;
                if (first_cyc != 2 || last_cyc - first_cyc != 3) begin
                    failures++;
                    $display("[TB] FAIL throughput first got=%0d exp=2 span got=%0d exp=3",
                             first_cyc, last_cyc - first_cyc);
                end
            end else begin
                checks++;
                if (stall_seen != 3 || stable_bad != 0) begin
                    failures++;
                    $display("[TB] FAIL hold_stable stalled got=%0d exp=3 changes got=%0d exp=0",
                             stall_seen, stable_bad);
                end
            end
        end
    endtask

`ifdef WEIGHT_BANK_WR_EN
    task automatic test_write;
        int cyc, rbad, rseen;
        logic rdy, ev, lv;
        logic [9:0]  ga;
        logic [31:0] gw;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 10'd5;
        wr_en     = 1'b1;
        wr_class  = 2'd2;
        wr_addr   = 10'd5;
        wr_data   = 8'h55;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_weights !== pack4(-8, 8, -3, 3)) begin
            failures++;
            $display("[TB] FAIL read_first valid=%b weights got=%h exp=%h", rsp_valid, rsp_weights, pack4(-8, 8, -3, 3));
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_weights !== pack4(-8, 8, 'h55, 3)) begin
            failures++;
            $display("[TB] FAIL write_visible valid=%b weights got=%h exp=%h", rsp_valid, rsp_weights, pack4(-8, 8, 'h55, 3));
        end
        @(negedge clk);
        // Restart INIT and attempt a write late in INIT to an already-filled cell.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1000) @(negedge clk);
        wr_en    = 1'b1;
        wr_class = 2'd0;
        wr_addr  = 10'd0;
        wr_data  = 8'h33;
        @(negedge clk);
        wr_en = 1'b0;
        wait_init(cyc, rbad, rseen);
        read_once(10'd0, rdy, ev, lv, ga, gw);
        checks++;
        if (lv !== 1'b1 || gw !== pack4(-8, 8, -8, 8)) begin
            failures++;
            $display("[TB] FAIL init_write_ignored weights got=%h exp=%h", gw, pack4(-8, 8, -8, 8));
        end
        read_once(10'd5, rdy, ev, lv, ga, gw);
        checks++;
        if (lv !== 1'b1 || gw !== pack4(-8, 8, -3, 3)) begin
            failures++;
            $display("[TB] FAIL write_restored weights got=%h exp=%h", gw, pack4(-8, 8, -3, 3));
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_run;
        int cyc, rbad, rseen;
        logic rdy, ev, lv;
        logic [9:0]  ga;
        logic [31:0] gw;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 10'd768;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || init_busy !== 1'b1 || req_ready !== 1'b0 ||
            rsp_addr !== 10'd0 || rsp_weights !== 32'd0) begin
            failures++;
            $display("[TB] FAIL midrun_reset valid=%b busy=%b ready=%b addr=%h weights=%h exp=0/1/0/0/0",
                     rsp_valid, init_busy, req_ready, rsp_addr, rsp_weights);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(cyc, rbad, rseen);
        checks++;
        if (cyc != 1024 || rseen != 0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrun_regen init got=%0d exp=1024 stray_rsp got=%0d exp=0", cyc, rseen);
        end
        read_once(10'd5, rdy, ev, lv, ga, gw);
        checks++;
        if (lv !== 1'b1 || ga !== 10'd5 || gw !== pack4(-8, 8, -3, 3)) begin
            failures++;
            $display("[TB] FAIL midrun_default weights got=%h exp=%h", gw, pack4(-8, 8, -3, 3));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_init;
        int cyc, rbad, rseen;
        logic rdy, ev, lv;
        logic [9:0]  ga;
        logic [31:0] gw;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (init_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midinit_busy got=%b exp=1", init_busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(cyc, rbad, rseen);
        checks++;
        if (cyc != 1024 || rbad != 0) begin
            failures++;
            $display("[TB] FAIL midinit_length got=%0d exp=1024 ready_high=%0d", cyc, rbad);
        end
        read_once(10'd1023, rdy, ev, lv, ga, gw);
        checks++;
        if (lv !== 1'b1 || gw !== pack4(-8, 8, -8, 8)) begin
            failures++;
            $display("[TB] FAIL midinit_default weights got=%h exp=%h", gw, pack4(-8, 8, -8, 8));
        end
        @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        rsp_ready   = 1'b1;
        s_req_valid = 1'b0;
        s_req_addr  = '0;
        s_rsp_ready = 1'b1;
`ifdef WEIGHT_BANK_WR_EN
        wr_en       = 1'b0;
        wr_class    = '0;
        wr_addr     = '0;
        wr_data     = '0;
        s_wr_en     = 1'b0;
        s_wr_class  = '0;
        s_wr_addr   = '0;
        s_wr_data   = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        test_reset;
        test_init_timing;
        test_defaults;
        test_saturation;
        test_back_to_back;
`ifdef WEIGHT_BANK_WR_EN
        test_write;
`endif
        test_reset_mid_run;
        test_reset_mid_init;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
